// File: rtl/wb_block_reader.sv
// rtl/wb_block_reader.sv - Wishbone classic block reader streaming words to a valid/ready port
// Optional feature macro: WB_TIMEOUT_EN (ack watchdog, limit set by TIMEOUT)
module wb_block_reader #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_adr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] wbm_adr_o,
  input  logic [31:0]           wbm_dat_i,
  output logic [3:0]            wbm_sel_o,
  output logic                  wbm_we_o,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  input  logic                  wbm_ack_i,
  input  logic                  wbm_err_i,
  output logic [31:0]           m_data,
  output logic                  m_valid,
  input  logic                  m_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_OUT  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [31:0]           m_data_q, m_data_d;
  logic                  m_valid_q, m_valid_d;
  logic                  cyc_q, cyc_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

`ifdef WB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit;
  // Watchdog fires on the last allowed REQ cycle so cyc is high exactly TIMEOUT cycles
  assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));
  logic unused_ok;
  assign unused_ok = ^base_adr[1:0];
`else
  logic unused_ok;
  assign unused_ok = ^{base_adr[1:0], 32'(TIMEOUT)};
`endif

  // Next-state and registered-output computation for the transfer FSM
  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    cnt_d     = cnt_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    cyc_d     = cyc_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef WB_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            adr_d   = {base_adr[ADDR_WIDTH-1:2], 2'b00};
            cnt_d   = len;
            busy_d  = 1'b1;
            cyc_d   = 1'b1;
`ifdef WB_TIMEOUT_EN
            tmo_d   = '0;
`endif
            state_d = S_REQ;
          end else begin
            // Empty block: finish without touching the bus
            done_d  = 1'b1;
            state_d = S_FIN;
          end
        end
      end
      S_REQ: begin
        if (wbm_err_i) begin
          // Error takes priority over a simultaneous ack
          cyc_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_FIN;
        end else if (wbm_ack_i) begin
          cyc_d     = 1'b0;
          m_data_d  = wbm_dat_i;
          m_valid_d = 1'b1;
          state_d   = S_OUT;
        end
`ifdef WB_TIMEOUT_EN
        else if (tmo_hit) begin
          cyc_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      S_OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          adr_d     = adr_q + ADDR_WIDTH'(4);
          cnt_d     = cnt_q - 1'b1;
          if (cnt_q == LEN_WIDTH'(1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            cyc_d   = 1'b1;
`ifdef WB_TIMEOUT_EN
            tmo_d   = '0;
`endif
            state_d = S_REQ;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      adr_q     <= '0;
      cnt_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      cyc_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef WB_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      cnt_q     <= cnt_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      cyc_q     <= cyc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef WB_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign wbm_adr_o = adr_q;
  assign wbm_sel_o = 4'hF;
  assign wbm_we_o  = 1'b0;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;

endmodule

// File: tb/tb_wb_block_reader.sv
// tb/tb_wb_block_reader.sv - scoreboard testbench for wb_block_reader
module tb_wb_block_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_adr = '0;
  logic [15:0] len = '0;
  logic        busy, done, err;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_i = '0;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic        wbm_ack_i = 1'b0;
  logic        wbm_err_i = 1'b0;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;

  int compared = 0;
  int mismatched = 0;

  // Slave behaviour knobs
  int ws = 0;
  int err_at = -1;
  bit no_ack = 1'b0;
  int wcnt = 0;
  int acc = 0;

  logic [31:0] exp_adr[$];
  logic [31:0] exp_dat[$];
  logic        exp_err[$];

  wb_block_reader #(.ADDR_WIDTH(32), .LEN_WIDTH(16), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_adr(base_adr), .len(len),
    .busy(busy), .done(done), .err(err),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_i(wbm_dat_i), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  // Registered memory slave: word at address A reads as {16'hD000, A[15:0]}
  always @(posedge clk) begin
    wbm_ack_i <= 1'b0;
    wbm_err_i <= 1'b0;
    wbm_dat_i <= 32'hDEADBEEF;
    if (!rst_n || !busy) begin
      wcnt <= 0;
      acc  <= 0;
    end else if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i && !wbm_err_i && !no_ack) begin
      if (wcnt == ws) begin
        wcnt <= 0;
        acc  <= acc + 1;
        if (acc == err_at) wbm_err_i <= 1'b1;
        else begin
          wbm_ack_i <= 1'b1;
          wbm_dat_i <= {16'hD000, wbm_adr_o[15:0]};
        end
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  // Bus monitor: every completed access must match the next expected address
  always @(negedge clk) begin
    if (rst_n && wbm_cyc_o && (wbm_ack_i || wbm_err_i)) begin
      if (exp_adr.size() == 0) chk("unexpected_bus_access", 32'd1, 32'd0);
      else begin
        chk("bus_adr", wbm_adr_o, exp_adr.pop_front());
        chk("bus_ctl", {27'd0, wbm_stb_o, wbm_sel_o}, {27'd0, 1'b1, 4'hF});
      end
    end
  end

  // Stream monitor: data must match in order and stay stable while stalled
  always @(negedge clk) begin
    if (rst_n && m_valid) begin
      if (exp_dat.size() == 0) chk("unexpected_stream_word", 32'd1, 32'd0);
      else if (m_ready) chk("stream_data", m_data, exp_dat.pop_front());
      else chk("stream_stall_data", m_data, exp_dat[0]);
    end
  end

  // Completion monitor: every done pulse must be expected, with matching err
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_err.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        chk("done_err", {31'd0, err}, {31'd0, exp_err.pop_front()});
        chk("done_busy_low", {31'd0, busy}, 32'd0);
      end
    end else if (rst_n && err) begin
      chk("err_without_done", 32'd1, 32'd0);
    end
  end

  task automatic pulse_start(input logic [31:0] b, input logic [15:0] l);
    @(negedge clk);
    start = 1'b1; base_adr = b; len = l;
    @(negedge clk);
    start = 1'b0; base_adr = 32'hFFFF_FFFF; len = 16'hFFFF;
  endtask

  task automatic wait_done(input string name, input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk(name, 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_valid(input int limit);
    int n;
    n = 0;
    while (!m_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!m_valid) chk("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    // T1 reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    chk("rst_cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
    chk("rst_adr", wbm_adr_o, 32'd0);
    chk("rst_mdata", m_data, 32'd0);
    chk("rst_mvalid", {31'd0, m_valid}, 32'd0);
    chk("rst_we_sel", {27'd0, wbm_we_o, wbm_sel_o}, 32'h0000000F);
    rst_n = 1'b1;

    // T2 four words, zero-wait slave, plus an ignored start while busy
    ws = 0; err_at = -1; m_ready = 1'b1;
    exp_adr.push_back(32'h100); exp_adr.push_back(32'h104);
    exp_adr.push_back(32'h108); exp_adr.push_back(32'h10C);
    exp_dat.push_back(32'hD0000100); exp_dat.push_back(32'hD0000104);
    exp_dat.push_back(32'hD0000108); exp_dat.push_back(32'hD000010C);
    exp_err.push_back(1'b0);
    pulse_start(32'h100, 16'd4);
    chk("t2_busy_after_start", {30'd0, busy, wbm_cyc_o}, 32'd3);
    @(negedge clk);
    start = 1'b1; base_adr = 32'h800; len = 16'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done("t2_done_timeout", 100);
    chk("t2_idle_after", {30'd0, busy, wbm_cyc_o}, 32'd0);

    // T3 unaligned base, two wait states, consumer stalls word 0
    ws = 2; m_ready = 1'b0;
    exp_adr.push_back(32'h100); exp_adr.push_back(32'h104);
    exp_dat.push_back(32'hD0000100); exp_dat.push_back(32'hD0000104);
    exp_err.push_back(1'b0);
    pulse_start(32'h103, 16'd2);
    wait_valid(50);
    repeat (5) @(negedge clk);
    chk("t3_no_cyc_while_stalled", {31'd0, wbm_cyc_o}, 32'd0);
    m_ready = 1'b1;
    wait_done("t3_done_timeout", 100);

    // T4 bus error on second access of three
    ws = 0; err_at = 1;
    exp_adr.push_back(32'h200); exp_adr.push_back(32'h204);
    exp_dat.push_back(32'hD0000200);
    exp_err.push_back(1'b1);
    pulse_start(32'h200, 16'd3);
    wait_done("t4_done_timeout", 100);
    chk("t4_busy_after", {30'd0, busy, wbm_cyc_o}, 32'd0);
    err_at = -1;

    // T5 zero-length request: done next cycle, no bus activity
    exp_err.push_back(1'b0);
    pulse_start(32'h300, 16'd0);
    chk("t5_done_pulse", {29'd0, done, busy, wbm_cyc_o}, 32'd4);
    @(negedge clk);
    chk("t5_done_one_cycle", {30'd0, done, wbm_cyc_o}, 32'd0);

`ifdef WB_TIMEOUT_EN
    // T6 slave never answers: watchdog aborts after exactly 16 REQ cycles
    begin
      int cyc_cnt;
      int n;
      cyc_cnt = 0;
      n = 0;
      no_ack = 1'b1;
      exp_err.push_back(1'b1);
      pulse_start(32'h500, 16'd2);
      while (!done && n < 100) begin
        if (wbm_cyc_o) cyc_cnt++;
        @(negedge clk);
        n++;
      end
      chk("t6_timeout_cycles", cyc_cnt, 32'd16);
      if (!done) chk("t6_done_timeout", 32'd0, 32'd1);
      @(negedge clk);
      no_ack = 1'b0;
    end
`endif

    // Reset in the middle of a stalled transfer: no done pulse afterwards
    no_ack = 1'b1;
    pulse_start(32'h400, 16'd3);
    repeat (3) @(negedge clk);
    chk("rst_mid_cyc_before", {31'd0, wbm_cyc_o}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_outputs", {28'd0, busy, done, wbm_cyc_o, m_valid}, 32'd0);
    chk("rst_mid_adr", wbm_adr_o, 32'd0);
    rst_n = 1'b1;
    no_ack = 1'b0;
    repeat (10) @(negedge clk);

    chk("left_adr", exp_adr.size(), 32'd0);
    chk("left_dat", exp_dat.size(), 32'd0);
    chk("left_err", exp_err.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
